// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the sum_bcd_converter block: FSM states,
// digit/segment widths, seven-segment pattern table and the add-3 helper.
package sum_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int SEG_W       = 7;

  // Active-low segments packed as {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  function automatic logic [BCD_DIGIT_W-1:0] add3(input logic [BCD_DIGIT_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/sum_bcd_converter_7seg.sv
// bcd_to_7seg: combinational BCD digit to active-low seven-segment decoder.
// Codes 10..15 cannot come out of the converter and decode to all-off.
module bcd_to_7seg
  import sum_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [SEG_W-1:0]       seg_o
);

  always_comb begin
    // NOTE: assigning a default before any condition keeps this block free of inferred latches.
    seg_o = SEG_BLANK;
    if (digit_i < 4'd10) seg_o = SEG_TABLE[digit_i];
  end

endmodule

// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter: WIDTH-bit binary to DIGITS BCD digits,
// one bit per clock. Define SUM_BCD_SSD_EN to add the registered seg_out port.
module sum_bcd_converter
  import sum_bcd_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              sum_in,
  output logic                          out_valid,
  output logic                          busy,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
`ifdef SUM_BCD_SSD_EN
  ,
  output logic [SEG_W*DIGITS-1:0]       seg_out
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  if (2**WIDTH - 1 > 10**DIGITS - 1) begin : g_range_err
    $error("sum_bcd_converter: DIGITS=%0d cannot hold 2^%0d-1", DIGITS, WIDTH);
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   scr_adj, scr_shift;

  // Add-3 correction on every scratch digit, then the shifted-in binary MSB.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      scr_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W] = add3(scr_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    scr_shift = {scr_adj[BCD_W-2:0], bin_q[WIDTH-1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = sum_in;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_shift;
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          bcd_d   = scr_shift;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;

`ifdef SUM_BCD_SSD_EN
  logic [SEG_W*DIGITS-1:0] seg_d, seg_q;

  // Decoding bcd_d keeps seg_out changing on exactly the edge bcd_out does.
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_to_7seg u_seg (
      .digit_i (bcd_d[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .seg_o   (seg_d[g*SEG_W +: SEG_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) seg_q <= {DIGITS{SEG_TABLE[0]}};
    else        seg_q <= seg_d;
  end

  assign seg_out = seg_q;
`endif

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Self-checking bench for sum_bcd_converter: directed latency/hold/reset cases,
// exhaustive and randomized values against an arithmetic reference model.
module tb_sum_bcd_converter;

  localparam int WIDTH  = 9;
  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  sum_in;
  logic        out_valid;
  logic        busy;
  logic [11:0] bcd_out;
`ifdef SUM_BCD_SSD_EN
  logic [20:0] seg_out;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [6:0] seg_tbl [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  sum_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .out_valid (out_valid),
    .busy      (busy),
    .bcd_out   (bcd_out)
`ifdef SUM_BCD_SSD_EN
    ,
    .seg_out   (seg_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of run, required $finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] exp_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] exp_seg(input int v);
    return {seg_tbl[v / 100 % 10], seg_tbl[v / 10 % 10], seg_tbl[v % 10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, then offers v for exactly one acceptance edge.
  task automatic present(input int v);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    sum_in   = 9'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic convert(input string tag, input int v, input bit noise);
    int k = 0;
    int busy_n = 0;
    present(v);
    if (busy) busy_n++;
    check({tag, " ready_low"}, 32'(in_ready), 32'd0);
    while (k < 20) begin
      if (noise) begin
        in_valid = 1'($urandom);
        sum_in   = 9'($urandom);
      end
      @(posedge clk); #1; k++;
      if (busy) busy_n++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 32'(k), 32'(WIDTH));
    check({tag, " bcd"}, 32'(bcd_out), 32'(exp_bcd(v)));
`ifdef SUM_BCD_SSD_EN
    check({tag, " seg"}, 32'(seg_out), 32'(exp_seg(v)));
`endif
    @(posedge clk); #1;
    check({tag, " pulse_end"}, 32'(out_valid), 32'd0);
    check({tag, " ready_back"}, 32'(in_ready), 32'd1);
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(WIDTH + 1));
  endtask

  initial begin
    int k;
    int pulses;
    int sweep [5] = '{0, 128, 255, 510, 511};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    sum_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst bcd", 32'(bcd_out), 32'h000);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
`ifdef SUM_BCD_SSD_EN
    check("rst seg", 32'(seg_out), 32'({3{7'b1000000}}));
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    convert("v12", 12, 1'b0);

    foreach (sweep[i]) convert($sformatf("sweep%0d", sweep[i]), sweep[i], 1'b0);

    // in_valid held through a conversion: the changed value waits for IDLE.
    in_valid = 1'b1;
    sum_in   = 9'd77;
    @(posedge clk); #1;
    sum_in = 9'd300;
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1; k++;
      if (out_valid) break;
    end
    check("hold first_latency", 32'(k), 32'(WIDTH));
    check("hold first_bcd", 32'(bcd_out), 32'h077);
    k = 0;
    while (k < 30) begin
      @(posedge clk); #1; k++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check("hold second_gap", 32'(k), 32'(WIDTH + 2));
    check("hold second_bcd", 32'(bcd_out), 32'h300);
    @(posedge clk); #1;

    // Reset during the fourth shift cycle of 499.
    pulses = 0;
    present(499);
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort bcd", 32'(bcd_out), 32'h000);
    check("abort busy", 32'(busy), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
`ifdef SUM_BCD_SSD_EN
    check("abort seg", 32'(seg_out), 32'({3{7'b1000000}}));
`endif
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("abort no_pulse", 32'(pulses), 32'd0);
    convert("after_abort499", 499, 1'b0);

    for (int v = 0; v < 512; v++) convert($sformatf("exh%0d", v), v, 1'b1);

    for (int r = 0; r < 64; r++) begin
      int v   = int'($urandom_range(511, 0));
      int gap = int'($urandom_range(3, 0));
      repeat (gap) begin
        @(posedge clk); #1;
      end
      convert($sformatf("rnd%0d", v), v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
